// File: rtl/mu0_ctrl.sv
// MU0 fetch/execute sequencer: drives PC/IR/ACC enables, address/PC muxes, ALU function
// and a req/ack memory port, with a memory-wait watchdog and halt/error reporting.
module mu0_ctrl #(
    parameter int OPW     = 4,
    parameter int CNTW    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rs,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    input  logic           acc_zero,
    input  logic           acc_neg,
    input  logic           mem_ack,
    output logic           mem_req,
    output logic           mem_wr,
    output logic           addr_sel,
    output logic           pc_sel,
    output logic [1:0]     alu_fn,
    output logic           ir_en,
    output logic           pc_en,
    output logic           acc_en,
    output logic           reg_rs,
    output logic           halted,
    output logic           err,
    output logic [2:0]     state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FETCH  = 3'd2,
        S_DECODE = 3'd3,
        S_MEMRD  = 3'd4,
        S_MEMWR  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [OPW-1:0] OP_LDA = OPW'(0);
    localparam logic [OPW-1:0] OP_STO = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB = OPW'(3);
    localparam logic [OPW-1:0] OP_JMP = OPW'(4);
    localparam logic [OPW-1:0] OP_JGE = OPW'(5);
    localparam logic [OPW-1:0] OP_JNE = OPW'(6);
    localparam logic [OPW-1:0] OP_STP = OPW'(7);

    localparam logic [CNTW-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : CNTW'(TIMEOUT - 1);

    state_t          state, state_n;
    logic            err_q, err_n;
    logic [CNTW-1:0] wcnt;
    logic            wd_last;

    // Last permitted unacked cycle; an ack in this same cycle still wins.
    assign wd_last   = (TIMEOUT != 0) && (wcnt == WD_LAST);
    assign err       = err_q;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            state <= S_IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            err_q <= err_n;
        end
    end

    // Wait counter restarts on every state change, so each access gets a fresh budget.
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            wcnt <= '0;
        end else if (state_n != state) begin
            wcnt <= '0;
        end else if (mem_req && !mem_ack) begin
            wcnt <= wcnt + CNTW'(1);
        end
    end

    always_comb begin
        state_n  = state;
        err_n    = err_q;
        mem_req  = 1'b0;
        mem_wr   = 1'b0;
        addr_sel = 1'b0;
        pc_sel   = 1'b0;
        alu_fn   = 2'b00;
        ir_en    = 1'b0;
        pc_en    = 1'b0;
        acc_en   = 1'b0;
        reg_rs   = 1'b0;
        halted   = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) state_n = S_CLEAR;
            end
            S_CLEAR: begin
                reg_rs  = 1'b1;
                pc_en   = 1'b1;
                acc_en  = 1'b1;
                state_n = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_en   = 1'b1;
                    pc_en   = 1'b1;
                    state_n = S_DECODE;
                end else if (wd_last) begin
                    state_n = S_HALT;
                    err_n   = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: state_n = S_MEMRD;
                    OP_STO: state_n = S_MEMWR;
                    OP_JMP: begin
                        pc_en   = 1'b1;
                        pc_sel  = 1'b1;
                        state_n = S_FETCH;
                    end
                    OP_JGE: begin
                        pc_en   = ~acc_neg;
                        pc_sel  = ~acc_neg;
                        state_n = S_FETCH;
                    end
                    OP_JNE: begin
                        pc_en   = ~acc_zero;
                        pc_sel  = ~acc_zero;
                        state_n = S_FETCH;
                    end
                    OP_STP: begin
                        state_n = S_HALT;
                        err_n   = 1'b0;
                    end
                    default: begin
                        state_n = S_HALT;
                        err_n   = 1'b1;
                    end
                endcase
            end
            S_MEMRD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (opcode == OP_ADD)      alu_fn = 2'b01;
                else if (opcode == OP_SUB) alu_fn = 2'b10;
                else                       alu_fn = 2'b00;
                if (mem_ack) begin
                    acc_en  = 1'b1;
                    state_n = S_FETCH;
                end else if (wd_last) begin
                    state_n = S_HALT;
                    err_n   = 1'b1;
                end
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                mem_wr   = 1'b1;
                addr_sel = 1'b1;
                if (mem_ack) begin
                    state_n = S_FETCH;
                end else if (wd_last) begin
                    state_n = S_HALT;
                    err_n   = 1'b1;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (!run) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        if (state_n == S_IDLE) err_n = 1'b0;
    end

endmodule

// File: tb/tb_mu0_ctrl.sv
// Directed bench for mu0_ctrl: the driver queues hand-computed output vectors per cycle,
// a negedge monitor pops and compares them.
module tb_mu0_ctrl;

    logic       clk = 1'b0;
    logic       rs = 1'b1;
    logic       run = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       acc_zero = 1'b0;
    logic       acc_neg = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_wr, addr_sel, pc_sel;
    logic [1:0] alu_fn;
    logic       ir_en, pc_en, acc_en, reg_rs, halted, err;
    logic [2:0] state_dbg;

    mu0_ctrl #(.OPW(4), .CNTW(8), .TIMEOUT(4)) dut (
        .clk(clk), .rs(rs), .run(run), .opcode(opcode),
        .acc_zero(acc_zero), .acc_neg(acc_neg), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_wr(mem_wr), .addr_sel(addr_sel), .pc_sel(pc_sel),
        .alu_fn(alu_fn), .ir_en(ir_en), .pc_en(pc_en), .acc_en(acc_en),
        .reg_rs(reg_rs), .halted(halted), .err(err), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // {mem_req, mem_wr, addr_sel, pc_sel, alu_fn, ir_en, pc_en, acc_en, reg_rs, halted, err}
    localparam int W = 12;
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           pass_cnt = 0;
    int           total_cnt = 0;

    function automatic logic [W-1:0] ov(input logic req, wr, asel, psel,
                                        input logic [1:0] fn,
                                        input logic ir, pc, acc, rrs, hlt, er);
        return {req, wr, asel, psel, fn, ir, pc, acc, rrs, hlt, er};
    endfunction

    localparam logic [W-1:0] ZERO = '0;

    // driver: one call per clock cycle
    task automatic cyc(input logic r, input logic rst, input logic [3:0] op,
                       input logic z, input logic n, input logic ack,
                       input logic [W-1:0] exp, input string nm);
        @(posedge clk);
        #1;
        run = r; rs = rst; opcode = op; acc_zero = z; acc_neg = n; mem_ack = ack;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [W-1:0] e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {mem_req, mem_wr, addr_sel, pc_sel, alu_fn, ir_en, pc_en, acc_en,
                  reg_rs, halted, err};
            total_cnt++;
            if (a === e) pass_cnt++;
            else $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    end

    logic [W-1:0] e_clr, e_fw, e_fa, e_jmp, e_hlt, e_hle;

    initial begin
        e_clr = ov(0,0,0,0,2'b00,0,1,1,1,0,0);
        e_fw  = ov(1,0,0,0,2'b00,0,0,0,0,0,0);
        e_fa  = ov(1,0,0,0,2'b00,1,1,0,0,0,0);
        e_jmp = ov(0,0,0,1,2'b00,0,1,0,0,0,0);
        e_hlt = ov(0,0,0,0,2'b00,0,0,0,0,1,0);
        e_hle = ov(0,0,0,0,2'b00,0,0,0,0,1,1);

        cyc(0,1,4'd0,0,0,0, ZERO, "reset");
        cyc(0,0,4'd0,0,0,0, ZERO, "idle");

        // start, fetch with ack in 3rd wait cycle
        cyc(1,0,4'd0,0,0,0, ZERO, "idle_run");
        cyc(1,0,4'd0,0,0,0, e_clr, "clear");
        cyc(0,0,4'd0,0,0,0, e_fw, "fetch_w1");
        cyc(0,0,4'd0,0,0,0, e_fw, "fetch_w2");
        cyc(0,0,4'd0,0,0,1, e_fa, "fetch_ack");

        // ADD, immediate ack
        cyc(0,0,4'd2,0,0,0, ZERO, "dec_add");
        cyc(0,0,4'd2,0,0,1, ov(1,0,1,0,2'b01,0,0,1,0,0,0), "memrd_add");
        cyc(0,0,4'd2,0,0,1, e_fa, "fetch_after_add");

        // conditional and unconditional jumps
        cyc(0,0,4'd5,0,1,0, ZERO, "jge_not_taken");
        cyc(0,0,4'd5,0,1,1, e_fa, "fetch_jge1");
        cyc(0,0,4'd5,0,0,0, e_jmp, "jge_taken");
        cyc(0,0,4'd5,0,0,1, e_fa, "fetch_jge2");
        cyc(0,0,4'd6,0,0,0, e_jmp, "jne_taken");
        cyc(0,0,4'd6,0,0,1, e_fa, "fetch_jne1");
        cyc(0,0,4'd6,1,0,0, ZERO, "jne_not_taken");
        cyc(0,0,4'd6,1,0,1, e_fa, "fetch_jne2");
        cyc(0,0,4'd4,1,1,0, e_jmp, "jmp");
        cyc(0,0,4'd4,0,0,1, e_fa, "fetch_jmp");

        // STO with one wait cycle
        cyc(0,0,4'd1,0,0,0, ZERO, "dec_sto");
        cyc(0,0,4'd1,0,0,0, ov(1,1,1,0,2'b00,0,0,0,0,0,0), "memwr_wait");
        cyc(0,0,4'd1,0,0,1, ov(1,1,1,0,2'b00,0,0,0,0,0,0), "memwr_ack");
        cyc(0,0,4'd1,0,0,1, e_fa, "fetch_sto");

        // LDA and SUB
        cyc(0,0,4'd0,0,0,0, ZERO, "dec_lda");
        cyc(0,0,4'd0,0,0,1, ov(1,0,1,0,2'b00,0,0,1,0,0,0), "memrd_lda");
        cyc(0,0,4'd0,0,0,1, e_fa, "fetch_lda");
        cyc(0,0,4'd3,0,0,0, ZERO, "dec_sub");
        cyc(0,0,4'd3,0,0,1, ov(1,0,1,0,2'b10,0,0,1,0,0,0), "memrd_sub");
        cyc(0,0,4'd3,0,0,1, e_fa, "fetch_sub");

        // STP, then illegal opcode
        cyc(1,0,4'd7,0,0,0, ZERO, "dec_stp");
        cyc(1,0,4'd7,0,0,0, e_hlt, "halt_stp");
        cyc(0,0,4'd7,0,0,0, e_hlt, "halt_release");
        cyc(1,0,4'd0,0,0,0, ZERO, "idle_restart");
        cyc(0,0,4'd0,0,0,0, e_clr, "clear2");
        cyc(0,0,4'd0,0,0,1, e_fa, "fetch_ill");
        cyc(0,0,4'hA,0,0,0, ZERO, "dec_illegal");
        cyc(1,0,4'hA,0,0,0, e_hle, "halt_illegal");
        cyc(0,0,4'hA,0,0,0, e_hle, "halt_illegal_rel");
        cyc(0,0,4'd0,0,0,0, ZERO, "idle_err_cleared");

        // watchdog: 4 unacked fetch cycles allowed, then HALT with err
        cyc(1,0,4'd0,0,0,0, ZERO, "idle_wd");
        cyc(0,0,4'd0,0,0,0, e_clr, "clear_wd");
        for (int i = 0; i < 4; i++) cyc(0,0,4'd0,0,0,0, e_fw, $sformatf("fetch_to%0d", i));
        cyc(1,0,4'd0,0,0,0, e_hle, "halt_timeout");
        cyc(0,0,4'd0,0,0,0, e_hle, "halt_timeout_rel");
        cyc(1,0,4'd0,0,0,0, ZERO, "idle_wd2");
        cyc(0,0,4'd0,0,0,0, e_clr, "clear_wd2");
        for (int i = 0; i < 3; i++) cyc(0,0,4'd0,0,0,0, e_fw, $sformatf("fetch_lw%0d", i));
        cyc(0,0,4'd0,0,0,1, e_fa, "fetch_ack_last");
        cyc(0,0,4'd2,0,0,0, ZERO, "dec_after_wait");
        for (int i = 0; i < 4; i++)
            cyc(0,0,4'd2,0,0,0, ov(1,0,1,0,2'b01,0,0,0,0,0,0), $sformatf("memrd_to%0d", i));
        cyc(1,0,4'd2,0,0,0, e_hle, "halt_memrd_timeout");
        cyc(0,0,4'd2,0,0,0, e_hle, "halt_memrd_rel");

        // asynchronous reset in the middle of an acked MEMRD
        cyc(1,0,4'd0,0,0,0, ZERO, "idle_rst");
        cyc(0,0,4'd0,0,0,0, e_clr, "clear_rst");
        cyc(0,0,4'd0,0,0,1, e_fa, "fetch_rst");
        cyc(0,0,4'd0,0,0,0, ZERO, "dec_rst");
        cyc(0,1,4'd0,0,0,1, ZERO, "rst_mid_memrd");
        cyc(0,0,4'd0,0,0,0, ZERO, "idle_after_rst");
        cyc(0,0,4'd0,0,0,0, ZERO, "idle_after_rst2");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
